native_mem_ctrl: RTL

Slave on the PicoRV32-style native memory bus, directly downstream of the multi-cycle `cpu`. It serves instruction fetches and data accesses from one on-chip word RAM with byte write strobes. It also provides a memory-mapped 8N1 UART transmitter for program output. Response latency is fixed by a wait-state counter, and UART writes are back-pressured while the transmitter is busy.

---
 rtl/native_mem_pkg.sv | 9 +
 rtl/native_mem_ctrl_uart_tx.sv | 36 +++
 rtl/native_mem_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/native_mem_pkg.sv
// native_mem_pkg: shared FSM/decode types and constants for native_mem_ctrl
package native_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_UART, REG_NONE} region_t;
  localparam logic [31:0] DEFAULT_UART_ADDR = 32'h1000_0000;
  function automatic region_t decode(input logic [31:0] a, input logic [31:0] ram_bytes, input logic [31:0] uart_addr);
    return a < ram_bytes ? REG_RAM : a[31:2] == uart_addr[31:2] ? REG_UART : REG_NONE;
  endfunction
endpackage

// File: rtl/native_mem_ctrl_uart_tx.sv
// uart_tx: 8N1 serial transmitter, one bit every CLK_DIV cycles
module uart_tx #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [9:0] sh;
  always_ff @(posedge clk)
    if (!reset_n) begin
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '1;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      idx <= '0;
      sh <= {1'b1, data, 1'b0};
    end else if (busy) begin
      if (cnt == CW'(CLK_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 4'd1;
        sh <= {1'b1, sh[9:1]};
        busy <= idx != 4'd9;
      end else cnt <= cnt + CW'(1);
    end
  assign tx = busy ? sh[0] : 1'b1;
endmodule

// File: rtl/native_mem_ctrl.sv
// native_mem_ctrl: native-bus slave serving a byte-strobed word RAM and a memory-mapped UART transmitter
module native_mem_ctrl
  import native_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] UART_ADDR   = DEFAULT_UART_ADDR,
  parameter int          CLK_DIV     = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t state, state_nx;
  region_t region;
  logic [3:0] wait_cnt;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic [31:0] ram [MEM_WORDS];
  logic [AW-1:0] idx;
  logic tx_busy, stall, go, tx_start;
  logic unused_ok;
  assign unused_ok = mem_instr;
  assign region = decode(addr, 32'(MEM_WORDS * 4), UART_ADDR);
  assign idx = addr[AW+1:2];
  assign tx_start = reset_n && go && region == REG_UART && wstrb[0];
  always_ff @(posedge clk) state <= reset_n ? state_nx : IDLE;
  always_comb
    state_nx = state == IDLE ? (mem_valid ? WAIT : IDLE) : state == WAIT ? (go ? RESP : WAIT) : IDLE;
  always_comb begin
    mem_ready = state == RESP;
    stall = region == REG_UART && wstrb[0] && tx_busy;
    go = state == WAIT && wait_cnt == 4'd0 && !stall;
  end
  // request fields are captured once and held until the response
  always_ff @(posedge clk)
    if (!reset_n) begin
      wait_cnt <= '0;
      mem_rdata <= '0;
    end else if (state == IDLE && mem_valid) begin
      wait_cnt <= 4'(WAIT_STATES);
      addr <= mem_addr;
      wdata <= mem_wdata;
      wstrb <= mem_wstrb;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt == 4'd0 ? 4'd0 : wait_cnt - 4'd1;
      if (go) mem_rdata <= region == REG_RAM ? ram[idx] : region == REG_UART ? {31'b0, tx_busy} : 32'h0;
    end
  always_ff @(posedge clk)
    if (reset_n && go && region == REG_RAM)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk(clk),
    .reset_n(reset_n),
    .start(tx_start),
    .data(wdata[7:0]),
    .tx(uart_tx),
    .busy(tx_busy)
  );
endmodule
